pixel_sink: RTL and testbench

Receiving end of the plotter pixel-write interface: accepts (colour, xPixel, yPixel, writeEn) writes from a plotter, buffers them in a small FIFO, and turns them into linear framebuffer RAM writes for the 160x120, 3-bit-colour display. It also owns an optional clear-screen sweep. It sits between the plotter(s) and the framebuffer memory feeding the VGA scanout.

---
 rtl/pixel_sink_if.sv | 36 +++
 rtl/pixel_sink.sv | 195 +++++++++++++++++++
 tb/tb_pixel_sink.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_sink_if.sv
// pixel_sink_if
// Groups the plotter pixel-write handshake, the clear-screen control and the
// framebuffer write port of pixel_sink into one bundle.
//   master : plotter / framebuffer side (drives pixel writes and clearReq,
//            observes ready, framebuffer strobes and status)
//   slave  : pixel_sink itself
// Signals:
//   colour[2:0], xPixel[7:0], yPixel[6:0], writeEn  pixel write request
//   ready                                           sink can accept a write
//   clearReq                                        single-cycle clear request
//   fb_addr[14:0], fb_data[2:0], fb_we              framebuffer write port
//   clearDone                                       end-of-sweep pulse
//   dropCount[7:0]                                  out-of-range write count
interface pixel_sink_if;
    logic [2:0]  colour;
    logic [7:0]  xPixel;
    logic [6:0]  yPixel;
    logic        writeEn;
    logic        ready;
    logic        clearReq;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        clearDone;
    logic [7:0]  dropCount;

    modport master (
        output colour, xPixel, yPixel, writeEn, clearReq,
        input  ready, fb_addr, fb_data, fb_we, clearDone, dropCount
    );

    modport slave (
        input  colour, xPixel, yPixel, writeEn, clearReq,
        output ready, fb_addr, fb_data, fb_we, clearDone, dropCount
    );
endinterface

// File: rtl/pixel_sink.sv
// pixel_sink
// Receiving end of the plotter pixel-write interface. Accepted in-range writes
// are buffered in a DEPTH-entry FIFO and drained one per cycle as linear
// framebuffer writes (addr = y*WIDTH + x). Out-of-range writes are consumed
// and counted in a saturating 8-bit counter.
//
// Optional clear-screen sweep, compiled in when PIXEL_SINK_CLEAR_EN is
// defined: a clearReq pulse drains the FIFO, then writes CLEAR_COLOUR to every
// framebuffer address and pulses clearDone. Without the macro clearReq is
// ignored and clearDone is tied low.
//
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  asynchronous active-high reset
//   bus      pixel_sink_if.slave (pixel writes, clear control, fb write port)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | normal operation; accept writes, pop one entry per cycle
// ST_DRAIN_WAIT| clear requested; input blocked, FIFO being emptied
// ST_CLEAR    | sweeping CLEAR_COLOUR over addresses 0..WIDTH*HEIGHT-1
module pixel_sink #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter int         DEPTH        = 4,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic         clk_i,
    input  logic         reset_i,
    pixel_sink_if.slave  bus
);

    localparam int          PTR_W     = $clog2(DEPTH);
    localparam logic [7:0]  X_LIM     = 8'(WIDTH);
    localparam logic [6:0]  Y_LIM     = 7'(HEIGHT);
    localparam logic [14:0] ROW_WORDS = 15'(WIDTH);

    typedef struct packed {
        logic [2:0] colour;
        logic [7:0] x;
        logic [6:0] y;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    entry_t         head;
    logic           empty, full, in_range, accept, push, pop, ready;
    logic [14:0]    pix_addr;

    logic [14:0]    fb_addr_q, fb_addr_d;
    logic [2:0]     fb_data_q, fb_data_d;
    logic           fb_we_q, fb_we_d;
    logic           clear_done_q, clear_done_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;

`ifdef PIXEL_SINK_CLEAR_EN
    localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN_WAIT,
        ST_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic        clear_pending_q, clear_pending_d;
    logic [14:0] clr_addr_q, clr_addr_d;
`else
    logic        unused_clear_req;
    assign unused_clear_req = bus.clearReq;
`endif

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign in_range = (bus.xPixel < X_LIM) && (bus.yPixel < Y_LIM);
    assign accept   = bus.writeEn && ready;
    assign push     = accept && in_range;

    // Constant multiply; for WIDTH=160 this reduces to (y<<7)+(y<<5)+x.
    assign pix_addr = 15'(head.y) * ROW_WORDS + 15'(head.x);

    assign drop_cnt_d = (accept && !in_range && (drop_cnt_q != 8'hFF))
                        ? drop_cnt_q + 8'd1 : drop_cnt_q;

    always_comb begin
        pop          = 1'b0;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clear_done_d = 1'b0;
`ifdef PIXEL_SINK_CLEAR_EN
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        clr_addr_d      = clr_addr_q;
        // ready is gated by reset so it reads low while reset is held.
        ready = !reset_i && !full && (state_q == ST_IDLE) && !clear_pending_q;
        case (state_q)
            ST_IDLE: begin
                pop = !empty;
                // clear_pending survives one IDLE cycle after the sweep so
                // clearDone lands in the cycle after the last clear write.
                if (clear_pending_q) begin
                    clear_pending_d = 1'b0;
                    clear_done_d    = 1'b1;
                end else if (bus.clearReq) begin
                    state_d         = ST_DRAIN_WAIT;
                    clear_pending_d = 1'b1;
                end
            end
            ST_DRAIN_WAIT: begin
                pop = !empty;
                if (empty) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                fb_we_d   = 1'b1;
                fb_addr_d = clr_addr_q;
                fb_data_d = CLEAR_COLOUR;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        ready = !reset_i && !full;
        pop   = !empty;
`endif
        if (pop) begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_addr;
            fb_data_d = head.colour;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
            clear_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= '{colour: bus.colour,
                                                x:      bus.xPixel,
                                                y:      bus.yPixel};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            clear_done_q <= clear_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

`ifdef PIXEL_SINK_CLEAR_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            clear_pending_q <= 1'b0;
            clr_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            clr_addr_q      <= clr_addr_d;
        end
    end
`endif

    assign bus.ready     = ready;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.clearDone = clear_done_q;
    assign bus.dropCount = drop_cnt_q;

endmodule

// File: tb/tb_pixel_sink.sv
// tb_pixel_sink
// Directed bench for pixel_sink: reset values, single-write latency, a
// 100-pixel back-to-back stream, the bottom-right boundary pixel, dropped
// writes and counter saturation, FIFO flush on reset, and either the clear
// sweep (PIXEL_SINK_CLEAR_EN) or clearReq being ignored (default build).
module tb_pixel_sink;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pixel_sink_if bus ();

    pixel_sink dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c);
        bus.writeEn = we;
        bus.xPixel  = x;
        bus.yPixel  = y;
        bus.colour  = c;
    endtask

`ifdef PIXEL_SINK_CLEAR_EN
    int px_idx, px_err, clr_idx, clr_err, rdy_err, done_cnt;
    logic [17:0] exp_px [3];

    task automatic clr_sample;
        if (bus.fb_we) begin
            if (px_idx < 3) begin
                if ({bus.fb_data, bus.fb_addr} !== exp_px[px_idx]) px_err++;
                px_idx++;
            end else begin
                if (bus.fb_addr !== 15'(clr_idx) || bus.fb_data !== 3'b000) clr_err++;
                clr_idx++;
            end
        end
        if (clr_idx > 0 && done_cnt == 0 && bus.ready) rdy_err++;
        if (bus.clearDone) done_cnt++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_we, cnt_rdy, cnt_done, bad_we, bad_addr;

        reset        = 1'b1;
        bus.clearReq = 1'b0;
        drive(0, 0, 0, 0);

        // reset values
        #12;
        chk("rst_ready", bus.ready, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        chk("rst_clear_done", bus.clearDone, 0);
        chk("rst_drop", bus.dropCount, 0);
        tick;
        reset = 1'b0;
        tick;
        chk("ready_after_rst", bus.ready, 1);

        // single write, visible two edges after accept
        drive(1, 8'd3, 7'd2, 3'b110);
        tick;
        drive(0, 0, 0, 0);
        chk("single_we_early", bus.fb_we, 0);
        tick;
        chk("single_we", bus.fb_we, 1);
        chk("single_addr", bus.fb_addr, 323);
        chk("single_data", bus.fb_data, 3'b110);
        tick;
        chk("single_we_after", bus.fb_we, 0);

        // 100 back-to-back writes on the diagonal
        cnt_rdy  = 0;
        bad_we   = 0;
        bad_addr = 0;
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) begin
                drive(1, 8'(i), 7'(i), 3'(i % 7 + 1));
                if (!bus.ready) cnt_rdy++;
            end else begin
                drive(0, 0, 0, 0);
            end
            tick;
            if (i >= 1) begin
                if (bus.fb_we !== 1'b1) bad_we++;
                if (bus.fb_addr !== 15'((i - 1) * 161)) bad_addr++;
            end
        end
        chk("b2b_ready_low_cycles", cnt_rdy, 0);
        chk("b2b_missing_we", bad_we, 0);
        chk("b2b_bad_addr", bad_addr, 0);
        tick;
        chk("b2b_we_after", bus.fb_we, 0);

        // bottom-right boundary pixel
        drive(1, 8'd159, 7'd119, 3'b101);
        tick;
        drive(0, 0, 0, 0);
        tick;
        chk("corner_we", bus.fb_we, 1);
        chk("corner_addr", bus.fb_addr, 19199);
        chk("corner_data", bus.fb_data, 3'b101);
        tick;

        // out-of-range writes are consumed but never reach the framebuffer
        cnt_we  = 0;
        cnt_rdy = 0;
        drive(1, 8'd160, 7'd0, 3'b111);
        if (!bus.ready) cnt_rdy++;
        tick;
        if (bus.fb_we) cnt_we++;
        drive(1, 8'd0, 7'd120, 3'b111);
        if (!bus.ready) cnt_rdy++;
        tick;
        if (bus.fb_we) cnt_we++;
        drive(1, 8'd255, 7'd127, 3'b111);
        if (!bus.ready) cnt_rdy++;
        tick;
        if (bus.fb_we) cnt_we++;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick;
            if (bus.fb_we) cnt_we++;
        end
        chk("drop_not_ready", cnt_rdy, 0);
        chk("drop_fb_we", cnt_we, 0);
        chk("drop_count3", bus.dropCount, 3);

        // saturation: 3 + 252 = 255, then 48 more must not wrap
        for (int i = 0; i < 252; i++) begin
            drive(1, 8'd200, 7'd5, 3'b001);
            tick;
        end
        drive(0, 0, 0, 0);
        tick;
        chk("drop_count_255", bus.dropCount, 255);
        for (int i = 0; i < 48; i++) begin
            drive(1, 8'd200, 7'd5, 3'b001);
            tick;
        end
        drive(0, 0, 0, 0);
        tick;
        chk("drop_count_sat", bus.dropCount, 255);

        // reset right after an accept flushes the FIFO
        drive(1, 8'd10, 7'd10, 3'b111);
        tick;
        drive(0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("flush_we_in_rst", bus.fb_we, 0);
        tick;
        reset  = 1'b0;
        cnt_we = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bus.fb_we) cnt_we++;
        end
        chk("flush_no_we", cnt_we, 0);
        chk("flush_drop_rst", bus.dropCount, 0);
        chk("flush_ready", bus.ready, 1);

`ifdef PIXEL_SINK_CLEAR_EN
        // clear with writes in flight and writeEn held throughout
        px_idx   = 0;
        px_err   = 0;
        clr_idx  = 0;
        clr_err  = 0;
        rdy_err  = 0;
        done_cnt = 0;
        exp_px[0] = {3'd1, 15'd170};
        exp_px[1] = {3'd2, 15'd340};
        exp_px[2] = {3'd3, 15'd510};
        drive(1, 8'd10, 7'd1, 3'd1);
        tick;
        clr_sample;
        drive(1, 8'd20, 7'd2, 3'd2);
        tick;
        clr_sample;
        drive(1, 8'd30, 7'd3, 3'd3);
        bus.clearReq = 1'b1;
        tick;
        clr_sample;
        bus.clearReq = 1'b0;
        drive(1, 8'd40, 7'd4, 3'd4);
        chk("clr_ready_drop", bus.ready, 0);
        begin
            logic pulsed;
            pulsed = 1'b0;
            for (int n = 0; n < 20100 && done_cnt == 0; n++) begin
                tick;
                clr_sample;
                if (clr_idx == 100 && !pulsed) begin
                    bus.clearReq = 1'b1;
                    pulsed       = 1'b1;
                end else begin
                    bus.clearReq = 1'b0;
                end
            end
        end
        drive(0, 0, 0, 0);
        chk("clr_done_seen", done_cnt, 1);
        chk("clr_px_count", px_idx, 3);
        chk("clr_px_err", px_err, 0);
        chk("clr_count", clr_idx, 19200);
        chk("clr_seq_err", clr_err, 0);
        chk("clr_ready_err", rdy_err, 0);
        chk("clr_ready_back", bus.ready, 1);
        tick;
        chk("clr_done_pulse", bus.clearDone, 0);
        chk("clr_we_after", bus.fb_we, 0);

        // reset in the middle of a sweep
        bus.clearReq = 1'b1;
        tick;
        bus.clearReq = 1'b0;
        cnt_we = 0;
        for (int n = 0; n < 6000 && cnt_we == 0; n++) begin
            tick;
            if (bus.fb_we && bus.fb_addr >= 15'd5000) cnt_we = 1;
        end
        chk("mid_clr_reached", cnt_we, 1);
        reset = 1'b1;
        #1;
        chk("mid_clr_we_rst", bus.fb_we, 0);
        tick;
        chk("mid_clr_ready_rst", bus.ready, 0);
        reset = 1'b0;
        cnt_we   = 0;
        cnt_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (bus.fb_we) cnt_we++;
            if (bus.clearDone) cnt_done++;
        end
        chk("mid_clr_no_we", cnt_we, 0);
        chk("mid_clr_no_done", cnt_done, 0);
        chk("mid_clr_ready", bus.ready, 1);
        drive(1, 8'd1, 7'd1, 3'd2);
        tick;
        drive(0, 0, 0, 0);
        tick;
        chk("mid_clr_idle_we", bus.fb_we, 1);
        chk("mid_clr_idle_addr", bus.fb_addr, 161);
        chk("mid_clr_idle_data", bus.fb_data, 2);
        tick;
`else
        // clearReq has no effect in the default build
        bus.clearReq = 1'b1;
        tick;
        bus.clearReq = 1'b0;
        cnt_we   = 0;
        cnt_rdy  = 0;
        cnt_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.ready) cnt_rdy++;
            tick;
            if (bus.fb_we) cnt_we++;
            if (bus.clearDone) cnt_done++;
        end
        chk("noclr_we", cnt_we, 0);
        chk("noclr_ready_low", cnt_rdy, 0);
        chk("noclr_done", cnt_done, 0);
        drive(1, 8'd7, 7'd1, 3'd4);
        tick;
        drive(0, 0, 0, 0);
        tick;
        chk("noclr_write_we", bus.fb_we, 1);
        chk("noclr_write_addr", bus.fb_addr, 167);
        tick;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
